// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's imem, redirect and decode-side signals.
// The master modport is the fetch stage; slave is the surrounding pipeline/memory.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_inst;

  modport master (
    output imem_addr, imem_rmask, out_valid, out_pc, out_pc_next, out_inst,
    input  imem_rdata, imem_resp, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, imem_rmask, out_valid, out_pc, out_pc_next, out_inst,
    output imem_rdata, imem_resp, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch front end: sequential PC generation, single-outstanding imem reads,
// an in-order registered output queue, and redirect flush with stale-response drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_stage_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // PEND: one request in flight; STALE: in flight but superseded by a redirect.
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_STALE} fst_t;

  fst_t          st_q, st_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q;
  entry_t        q_mem [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q, count_d;
  logic [PW:0]   pend_ext;
  logic          pending, stale, resp_ok, issue, enq, deq;
  entry_t        head;
  logic          unused_ok;

  assign pending  = (st_q != S_IDLE);
  assign stale    = (st_q == S_STALE);
  assign pend_ext = {{PW{1'b0}}, pending};
  assign resp_ok  = bus.imem_resp && pending;

  // Reserve a slot for the in-flight word; a same-cycle pop is deliberately ignored.
  assign issue = !rst && !bus.redirect_valid && (!pending || bus.imem_resp)
                 && ((count_q + pend_ext) < DEPTH_C);

  assign enq = resp_ok && !stale && !bus.redirect_valid;
  assign deq = (count_q != '0) && bus.out_ready && !bus.redirect_valid;

  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
      if (pending && !bus.imem_resp) st_d = S_STALE;
      else                           st_d = S_IDLE;
    end else if (issue) begin
      st_d = S_PEND;
      pc_d = pc_q + 32'd4;
    end else if (resp_ok) begin
      st_d = S_IDLE;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.redirect_valid)  count_d = '0;
    else if (enq && !deq)    count_d = count_q + CNT_ONE;
    else if (deq && !enq)    count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (issue) req_pc_q <= pc_q;
      if (bus.redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (enq) tail_q <= tail_q + PTR_ONE;
        if (deq) head_q <= head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) q_mem[tail_q] <= '{pc: req_pc_q, inst: bus.imem_rdata};
  end

  assign head            = q_mem[head_q];
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_pc      = bus.out_valid ? head.pc : '0;
  assign bus.out_pc_next = bus.out_valid ? head.pc + 32'd4 : '0;
  assign bus.out_inst    = bus.out_valid ? head.inst : '0;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_rmask  = issue ? 4'hF : 4'h0;

  assign unused_ok = &{1'b0, bus.redirect_pc[1:0]};

  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    (count_q + pend_ext) <= DEPTH_C);
  a_aligned: assert property (@(posedge clk) disable iff (rst) pc_q[1:0] == 2'b00);
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model of the fetch rules.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h1eceb000;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();
  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_pend, m_stale;
  int          n_chk, n_fail;
  bit          mem_busy;
  int          mem_cnt, lat;
  bit          rand_lat;
  logic [31:0] mem_addr;
  logic [31:0] iss_log[$];
  bit          last_iss;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          resp, m_issue;
    logic [31:0] rdata;
    ent_t        e;
    @(negedge clk);
    resp  = 1'b0;
    rdata = '0;
    if (r) mem_busy = 1'b0;
    else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        resp = 1'b1; rdata = inst_of(mem_addr); mem_busy = 1'b0;
      end
    end
    rst = r;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    bus.imem_resp      = resp;
    bus.imem_rdata     = resp ? rdata : $urandom;
    #1;
    m_issue = !r && !redir && (!m_pend || resp) && (mq.size() + int'(m_pend) < DEPTH);
    chk("imem_rmask", {28'd0, bus.imem_rmask}, m_issue ? 32'hF : 32'h0);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
    chk("out_pc", bus.out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("out_pc_next", bus.out_pc_next, (mq.size() != 0) ? mq[0].pc + 32'd4 : 32'h0);
    chk("out_inst", bus.out_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
    if (resp) chk("resp_pending", {31'd0, m_pend}, 32'd1);
    // The memory follows what the DUT actually requests.
    last_iss = !r && (bus.imem_rmask == 4'hF);
    if (last_iss) begin
      mem_busy = 1'b1;
      mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mem_addr = bus.imem_addr;
      iss_log.push_back(bus.imem_addr);
    end
    if (r) iss_log.delete();
    // Reference transition for the coming clock edge.
    if (r) begin
      m_pc = RST_PC; m_req_pc = '0; m_pend = 0; m_stale = 0; mq.delete();
    end else if (redir) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (m_pend && !resp) m_stale = 1;
      else if (m_pend) begin m_pend = 0; m_stale = 0; end
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (resp && m_pend) begin
        if (!m_stale) begin e.pc = m_req_pc; e.inst = rdata; mq.push_back(e); end
        m_pend = 0; m_stale = 0;
      end
      if (m_issue) begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_pend = 1; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_chk = 0; n_fail = 0; lat = 1; rand_lat = 0; mem_busy = 0; mem_cnt = 0; mem_addr = '0;
    m_pc = RST_PC; m_req_pc = '0; m_pend = 0; m_stale = 0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    bus.imem_resp = 1'b0; bus.imem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state, then latency-1 streaming.
    cycle(1, 0, '0, 1);
    repeat (10) cycle(0, 0, '0, 1);
    chk("stream_issues", 32'(iss_log.size()), 32'd10);
    for (int i = 0; i < 3 && i < iss_log.size(); i++)
      chk("stream_addr", iss_log[i], RST_PC + 32'(4 * i));

    // Backpressure: the queue plus the in-flight slot caps issue at DEPTH.
    cycle(1, 0, '0, 0);
    repeat (12) cycle(0, 0, '0, 0);
    chk("bp_issues", 32'(iss_log.size()), 32'd4);
    repeat (12) cycle(0, 0, '0, 1);
    chk("bp_resume", (iss_log.size() > 4) ? iss_log[4] : 32'h0, RST_PC + 32'h10);

    // Latency 3, redirect one cycle after the request to +8.
    lat = 3;
    cycle(1, 0, '0, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(0, 0, '0, 1);
      found = last_iss && (iss_log[$] == RST_PC + 32'h8);
    end
    chk("l3_req8_seen", {31'd0, found}, 32'd1);
    cycle(0, 1, 32'h1eceb100, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 0, '0, 1);
      found = last_iss;
      if (!found) chk("stale_quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    chk("redir_target", found ? iss_log[$] : 32'h0, 32'h1eceb100);

    // Redirect coinciding with a response and a dequeue; unaligned target.
    lat = 1;
    cycle(1, 0, '0, 1);
    repeat (6) cycle(0, 0, '0, 1);
    cycle(0, 1, 32'h1eceb102, 1);
    cycle(0, 0, '0, 1);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_issue", {31'd0, last_iss}, 32'd1);
    chk("flush_addr", bus.imem_addr, 32'h1eceb100);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(0, 0, '0, 0);
      found = bus.out_valid;
    end
    chk("flush_out_pc", found ? bus.out_pc : 32'h0, 32'h1eceb100);

    // Reset with three queued entries and one in flight.
    lat = 2;
    cycle(1, 0, '0, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(0, 0, '0, 0);
      found = (mq.size() == 3) && m_pend;
    end
    chk("pre_reset_fill", {31'd0, found}, 32'd1);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 1);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    repeat (8) cycle(0, 0, '0, 1);
    chk("rst_seq0", (iss_log.size() > 1) ? iss_log[0] : 32'h0, RST_PC);
    chk("rst_seq1", (iss_log.size() > 1) ? iss_log[1] : 32'h0, RST_PC + 32'd4);

    // Random traffic: varying latency, backpressure, redirects and resets.
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      bit r, rd, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = ($urandom_range(0, 1) == 0) ? RST_PC + 32'($urandom_range(0, 255)) : 32'($urandom);
      cycle(r, rd, tgt, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
